// File: rtl/fetch_stage_pkg.sv
// Constants and types shared by the IF stage, the ID stage and the core top level.
package fetch_stage_pkg;

    localparam int          FS2DS_LEN  = 64;
    localparam int          BR_ZIP_LEN = 33;
    localparam logic [31:0] RESET_PC   = 32'h1c000000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_zip_t;

endpackage

// File: rtl/fetch_inst_buf.sv
// One-entry skid buffer that keeps the fetched instruction alive while ID stalls,
// since the SRAM only drives valid data in the cycle right after an enabled read.
module fetch_inst_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fs_valid_i,
    input  logic        fs_allowin_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] fs_inst_o
);

    logic        buf_valid_q;
    logic        buf_valid_d;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_inst_d;

    // Any cycle that frees IF also empties the buffer, which covers both handoff and redirect.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if (fs_allowin_i) begin
            buf_valid_d = 1'b0;
        end else if (fs_valid_i && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign fs_inst_o = buf_valid_q ? buf_inst_q : rdata_i;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: generates the next PC, drives the instruction SRAM and offers {inst, pc} to ID,
// squashing the wrong-path instruction whenever ID returns a taken branch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter int          FS2DS_LEN = fetch_stage_pkg::FS2DS_LEN
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 inst_sram_en,
    output logic [3:0]           inst_sram_we,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic [31:0]          inst_sram_rdata,
    input  logic                 ds_allowin,
    input  logic [BR_ZIP_LEN-1:0] br_zip,
    output logic                 fs2ds_valid,
    output logic [FS2DS_LEN-1:0] fs2ds_bus
);

    localparam logic [31:0] PRE_RESET_PC = RESET_PC - 32'd4;
    localparam logic        FS_READY_GO  = 1'b1;

    br_zip_t     br;
    logic        to_fs_valid_q;
    logic        fs_valid_q;
    logic        fs_valid_d;
    logic [31:0] fs_pc_q;
    logic [31:0] fs_pc_d;
    logic [31:0] nextpc;
    logic        fs_allowin;
    logic [31:0] fs_inst;

    assign br     = br_zip;
    assign nextpc = br.taken ? br.target : fs_pc_q + 32'd4;

    // A redirect always frees IF so the target is fetched even while ID is stalled.
    assign fs_allowin = ~fs_valid_q | (FS_READY_GO & ds_allowin) | br.taken;

    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        if (fs_allowin) begin
            fs_valid_d = to_fs_valid_q;
            if (to_fs_valid_q) begin
                fs_pc_d = nextpc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_fs_valid_q <= 1'b0;
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= PRE_RESET_PC;
        end else begin
            to_fs_valid_q <= 1'b1;
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
        end
    end

    fetch_inst_buf u_inst_buf (
        .clk          (clk),
        .resetn       (resetn),
        .fs_valid_i   (fs_valid_q),
        .fs_allowin_i (fs_allowin),
        .rdata_i      (inst_sram_rdata),
        .fs_inst_o    (fs_inst)
    );

    // Outputs are forced quiet during the reset cycle itself, before the registers clear.
    assign inst_sram_en    = resetn & to_fs_valid_q & fs_allowin;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

    assign fs2ds_valid = resetn & fs_valid_q & ~br.taken;
    assign fs2ds_bus   = {fs_inst, fs_pc_q};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stalls, redirects, buffered redirect and reset pulse.
module tb_fetch_stage;

    logic        clk;
    logic        resetn;
    logic        instSramEn;
    logic [3:0]  instSramWe;
    logic [31:0] instSramAddr;
    logic [31:0] instSramWdata;
    logic [31:0] instSramRdata;
    logic        dsAllowin;
    logic [32:0] brZip;
    logic        fs2dsValid;
    logic [63:0] fs2dsBus;

    int vectorCount = 0;
    int missCount   = 0;
    logic [31:0] handoffLog[$];
    logic [31:0] expectedLog[10];

    fetch_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (instSramEn),
        .inst_sram_we    (instSramWe),
        .inst_sram_addr  (instSramAddr),
        .inst_sram_wdata (instSramWdata),
        .inst_sram_rdata (instSramRdata),
        .ds_allowin      (dsAllowin),
        .br_zip          (brZip),
        .fs2ds_valid     (fs2dsValid),
        .fs2ds_bus       (fs2dsBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is addr ^ 32'hffff0000; read data goes to X whenever no read is issued.
    always @(posedge clk) begin
        instSramRdata <= instSramEn ? (instSramAddr ^ 32'hffff0000) : 32'hx;
    end

    always @(posedge clk) begin
        if (fs2dsValid && dsAllowin) handoffLog.push_back(fs2dsBus[31:0]);
    end

    task automatic applyStimulus(input logic rstn, input logic allow,
                                 input logic taken, input logic [31:0] target);
        resetn    = rstn;
        dsAllowin = allow;
        brZip     = {taken, target};
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("rst_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("rst_en", 64'(instSramEn), 64'd0);
        checkOutput("rst_we", 64'(instSramWe), 64'd0);
        checkOutput("rst_wdata", 64'(instSramWdata), 64'd0);

        // First cycle after release: to_fs_valid still low, no read yet.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("c0_en", 64'(instSramEn), 64'd0);
        checkOutput("c0_addr", 64'(instSramAddr), 64'h1c000000);
        checkOutput("c0_valid", 64'(fs2dsValid), 64'd0);
        nextCycle();
        checkOutput("c1_en", 64'(instSramEn), 64'd1);
        checkOutput("c1_addr", 64'(instSramAddr), 64'h1c000000);
        checkOutput("c1_valid", 64'(fs2dsValid), 64'd0);
        nextCycle();
        checkOutput("c2_valid", 64'(fs2dsValid), 64'd1);
        checkOutput("c2_bus", fs2dsBus, 64'he3ff0000_1c000000);
        checkOutput("c2_addr", 64'(instSramAddr), 64'h1c000004);
        nextCycle();
        checkOutput("c3_bus", fs2dsBus, 64'he3ff0004_1c000004);
        checkOutput("c3_addr", 64'(instSramAddr), 64'h1c000008);

        // ID stalls for three cycles on pc 0x1c000008.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stall0_en", 64'(instSramEn), 64'd0);
        checkOutput("stall0_bus", fs2dsBus, 64'he3ff0008_1c000008);
        checkOutput("stall0_valid", 64'(fs2dsValid), 64'd1);
        nextCycle();
        checkOutput("stall1_en", 64'(instSramEn), 64'd0);
        checkOutput("stall1_bus", fs2dsBus, 64'he3ff0008_1c000008);
        nextCycle();
        checkOutput("stall2_en", 64'(instSramEn), 64'd0);
        checkOutput("stall2_bus", fs2dsBus, 64'he3ff0008_1c000008);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("unstall_en", 64'(instSramEn), 64'd1);
        checkOutput("unstall_addr", 64'(instSramAddr), 64'h1c00000c);
        checkOutput("unstall_bus", fs2dsBus, 64'he3ff0008_1c000008);

        // Single-cycle redirect while IF holds 0x1c00000c.
        nextCycle();
        checkOutput("handoff_cnt", 64'(handoffLog.size()), 64'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1c000100);
        checkOutput("br1_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("br1_addr", 64'(instSramAddr), 64'h1c000100);
        checkOutput("br1_en", 64'(instSramEn), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("br1_tgt_valid", 64'(fs2dsValid), 64'd1);
        checkOutput("br1_tgt_bus", fs2dsBus, 64'he3ff0100_1c000100);

        // Redirect held three cycles while ID stalls.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1c000200);
        checkOutput("brh0_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("brh0_addr", 64'(instSramAddr), 64'h1c000200);
        checkOutput("brh0_en", 64'(instSramEn), 64'd1);
        nextCycle();
        checkOutput("brh1_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("brh1_pc", 64'(fs2dsBus[31:0]), 64'h1c000200);
        nextCycle();
        checkOutput("brh2_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("brh2_pc", 64'(fs2dsBus[31:0]), 64'h1c000200);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("brh_rel_valid", 64'(fs2dsValid), 64'd1);
        checkOutput("brh_rel_bus", fs2dsBus, 64'he3ff0200_1c000200);
        checkOutput("brh_rel_addr", 64'(instSramAddr), 64'h1c000204);
        nextCycle();
        checkOutput("brh_next_bus", fs2dsBus, 64'he3ff0204_1c000204);

        // Stall fills the buffer, then a redirect must discard it.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("buf0_bus", fs2dsBus, 64'he3ff0208_1c000208);
        checkOutput("buf0_en", 64'(instSramEn), 64'd0);
        nextCycle();
        checkOutput("buf1_bus", fs2dsBus, 64'he3ff0208_1c000208);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1c000300);
        checkOutput("bufbr_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("bufbr_addr", 64'(instSramAddr), 64'h1c000300);
        checkOutput("bufbr_en", 64'(instSramEn), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("bufbr_tgt_valid", 64'(fs2dsValid), 64'd1);
        checkOutput("bufbr_tgt_bus", fs2dsBus, 64'he3ff0300_1c000300);

        // Steer to 0x1c000038, stream to 0x1c000040, then pulse reset.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1c000038);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("pre_rst_bus", fs2dsBus, 64'he3ff0040_1c000040);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_rst_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("mid_rst_en", 64'(instSramEn), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rerel_valid", 64'(fs2dsValid), 64'd0);
        checkOutput("rerel_en", 64'(instSramEn), 64'd0);
        checkOutput("rerel_addr", 64'(instSramAddr), 64'h1c000000);
        nextCycle();
        checkOutput("refetch_en", 64'(instSramEn), 64'd1);
        checkOutput("refetch_addr", 64'(instSramAddr), 64'h1c000000);
        nextCycle();
        checkOutput("refetch_valid", 64'(fs2dsValid), 64'd1);
        checkOutput("refetch_bus", fs2dsBus, 64'he3ff0000_1c000000);
        nextCycle();

        // Every fetched right-path PC handed off exactly once, wrong-path ones never.
        expectedLog = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c000100, 32'h1c000200,
                        32'h1c000204, 32'h1c000300, 32'h1c000038, 32'h1c00003c, 32'h1c000000};
        checkOutput("handoff_total", 64'(handoffLog.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("handoff_%0d", i),
                        64'((i < handoffLog.size()) ? handoffLog[i] : 32'hdeadbeef),
                        64'(expectedLog[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
